// File: rtl/mac_accumulator.sv
// Streaming signed multiply-accumulate core: sums data*weight over a frame, hands the sum out.
// Optional `MAC_SAT_EN clamps every partial sum instead of wrapping it modulo 2^(2*WIDTH).
module mac_accumulator #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [WIDTH-1:0]     dataIn,
  input  logic [WIDTH-1:0]     weightIn,
  input  logic                 inLast,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [2*WIDTH-1:0]   accOut,
  output logic [CNT_W-1:0]     termCount
);

  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [AW-1:0]       acc_r;
  logic [CNT_W-1:0]    count_r;
  logic signed [AW-1:0] data_ext_s;
  logic signed [AW-1:0] weight_ext_s;
  logic signed [AW-1:0] prod_s;
  logic signed [AW-1:0] base_s;
  logic [AW-1:0]       acc_nxt_s;
  logic                beat_s;
  logic                frame_end_s;

`ifdef MAC_SAT_EN
  logic [AW:0]         sum_s;

  // Clamp a one-bit-overflow sum back into the signed AW-bit range.
  function automatic logic [AW-1:0] sat_reduce(input logic [AW:0] s);
    if (s[AW] != s[AW-1]) begin
      sat_reduce = s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sat_reduce = s[AW-1:0];
    end
  endfunction
`endif

  // Operands are sign-extended so the AW-bit product is exact.
  assign data_ext_s   = {{WIDTH{dataIn[WIDTH-1]}}, dataIn};
  assign weight_ext_s = {{WIDTH{weightIn[WIDTH-1]}}, weightIn};
  assign prod_s       = data_ext_s * weight_ext_s;
  assign base_s       = (state_r == ACCUM) ? acc_r : {AW{1'b0}};
  assign beat_s       = inValid & (state_r != DONE);
  assign frame_end_s  = inLast | (count_r == CNT_W'(MAX_TERMS - 1));

`ifdef MAC_SAT_EN
  assign sum_s     = {base_s[AW-1], base_s} + {prod_s[AW-1], prod_s};
  assign acc_nxt_s = sat_reduce(sum_s);
`else
  assign acc_nxt_s = base_s + prod_s;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (beat_s) begin
          state_nxt_s = frame_end_s ? DONE : ACCUM;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE: begin
        if (outReady) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs; inReady is held low for as long as reset is applied.
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    case (state_r)
      IDLE, ACCUM: begin
        inReady  = ~rst;
        outValid = 1'b0;
      end
      DONE: begin
        inReady  = 1'b0;
        outValid = 1'b1;
      end
      default: begin
        inReady  = 1'b0;
        outValid = 1'b0;
      end
    endcase
  end

  // Accumulator and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= {AW{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (beat_s) begin
            acc_r   <= acc_nxt_s;
            count_r <= count_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (outReady) begin
            acc_r   <= {AW{1'b0}};
            count_r <= {CNT_W{1'b0}};
          end
        end
        default: begin
          acc_r   <= {AW{1'b0}};
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign accOut    = acc_r;
  assign termCount = count_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomised bench for mac_accumulator against a frame-level reference model.
module tb_mac_accumulator;
  localparam int WIDTH = 8, MAX_TERMS = 16, CNT_W = 5, AW = 16;
  localparam longint SMAX = 32767, SMIN = -32768;

  logic clk = 1'b0, rst, inValid, inLast, outReady, inReady, outValid;
  logic [WIDTH-1:0] dataIn, weightIn;
  logic [AW-1:0] accOut;
  logic [CNT_W-1:0] termCount;

  mac_accumulator #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .dataIn(dataIn),
    .weightIn(weightIn), .inLast(inLast), .outValid(outValid), .outReady(outReady),
    .accOut(accOut), .termCount(termCount));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit m_done = 1'b0, accepted = 1'b0;
  int m_cnt = 0;
  longint prods[$];
  longint m_sum = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame sum from the list of products, clamped or wrapped after each beat.
  function automatic longint frame_sum();
    longint s = 0;
    longint t;
    foreach (prods[i]) begin
      s += prods[i];
`ifdef MAC_SAT_EN
      if (s > SMAX) s = SMAX;
      else if (s < SMIN) s = SMIN;
`else
      t = (s + 32768) % 65536;
      if (t < 0) t += 65536;
      s = t - 32768;
`endif
    end
    return s;
  endfunction

  task automatic check_outputs();
    chk("inReady", longint'(inReady), longint'(!m_done));
    chk("outValid", longint'(outValid), longint'(m_done));
    chk("termCount", longint'(termCount), longint'(m_cnt));
    if (m_done) chk("accOut", longint'($signed(accOut)), m_sum);
  endtask

  task automatic model_update();
    accepted = 1'b0;
    if (m_done) begin
      if (outReady) begin
        m_done = 1'b0;
        m_cnt = 0;
        prods.delete();
      end
    end else if (inValid) begin
      accepted = 1'b1;
      prods.push_back(longint'($signed(dataIn)) * longint'($signed(weightIn)));
      m_cnt++;
      if (inLast || m_cnt == MAX_TERMS) begin
        m_done = 1'b1;
        m_sum = frame_sum();
      end
    end
  endtask

  task automatic model_reset();
    m_done = 1'b0;
    m_cnt = 0;
    prods.delete();
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(logic [WIDTH-1:0] d, logic [WIDTH-1:0] w, logic last);
    dataIn = d; weightIn = w; inLast = last; inValid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) chk("send_timeout", 0, 1);
    inValid = 1'b0; inLast = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int k = 0; k < 50 && m_done; k++) tick();
    if (m_done) chk("drain_timeout", 0, 1);
    outReady = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gaps, waits;
    bit hold;
    rst = 1'b1; inValid = 1'b0; inLast = 1'b0; outReady = 1'b0;
    dataIn = '0; weightIn = '0;
    #12;
    chk("rst_inReady", longint'(inReady), 0);
    chk("rst_accOut", longint'(accOut), 0);
    chk("rst_outValid", longint'(outValid), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rel_inReady", longint'(inReady), 1);
    @(posedge clk); #1;

    // 1: reset in the middle of a frame
    send(8'd5, 8'd5, 1'b0);
    send(8'd6, 8'd6, 1'b0);
    chk("t1_pre_cnt", longint'(termCount), 2);
    #2 rst = 1'b1; #1;
    chk("t1_accOut", longint'(accOut), 0);
    chk("t1_termCount", longint'(termCount), 0);
    chk("t1_outValid", longint'(outValid), 0);
    chk("t1_inReady", longint'(inReady), 0);
    model_reset();
    @(posedge clk); #1;
    chk("t1_inReady_hold", longint'(inReady), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t1_inReady_rel", longint'(inReady), 1);
    chk("t1_cnt_rel", longint'(termCount), 0);
    @(posedge clk); #1;

    // 2: three-beat frame held under backpressure
    send(8'd10, 8'd20, 1'b0);
    send(-8'sd5, 8'd4, 1'b0);
    send(8'd3, 8'd3, 1'b1);
    chk("t2_model", m_sum, 189);
    chk("t2_outValid", longint'(outValid), 1);
    chk("t2_accOut", longint'($signed(accOut)), 189);
    chk("t2_termCount", longint'(termCount), 3);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_accOut_held", longint'($signed(accOut)), 189);
    drain();

    // 3: single-beat frame
    send(-8'sd128, -8'sd128, 1'b1);
    chk("t3_accOut", longint'($signed(accOut)), 16384);
    chk("t3_termCount", longint'(termCount), 1);
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("t3_inReady", longint'(inReady), 1);
    chk("t3_outValid", longint'(outValid), 0);

    // 4: overflow, wrapped or clamped
    for (int i = 0; i < 4; i++) send(-8'sd128, -8'sd128, i == 3);
`ifdef MAC_SAT_EN
    chk("t4_accOut", longint'($signed(accOut)), 32767);
`else
    chk("t4_accOut", longint'($signed(accOut)), 0);
`endif
    drain();

    // 5: forced end at MAX_TERMS, then input offered while done
    for (int i = 0; i < 16; i++) send(8'd1, 8'd1, 1'b0);
    chk("t5_accOut", longint'($signed(accOut)), 16);
    chk("t5_termCount", longint'(termCount), 16);
    chk("t5_outValid", longint'(outValid), 1);
    dataIn = 8'd2; weightIn = 8'd2; inValid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_inReady", longint'(inReady), 0);
    chk("t5_termCount_held", longint'(termCount), 16);
    inValid = 1'b0;
    drain();

    // 6: random frames with input gaps and output stalls
    for (int f = 0; f < 200; f++) begin
      n = $urandom_range(1, 18);
      hold = ($urandom_range(0, 3) == 0);
      outReady = hold;
      for (int i = 0; i < n && !m_done; i++) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          inLast = 1'($urandom_range(0, 1));
          tick();
        end
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i == n - 1);
      end
      if (!m_done) chk("t6_frame_end", 0, 1);
      if (!hold) begin
        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) tick();
      end
      drain();
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
